// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like bus: access-size encodings and the
// byte-lane write mask used by both the memory slave and the data cache.
package sram_like_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  // Size 2'b11 falls into the default and behaves as a full word.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << addr_lo;
      SIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sram_like_mem_slave_if.sv
// SRAM-like request/response bus between an initiator and the memory slave.
interface sram_like_mem_slave_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/sram_req_fifo.sv
// In-order request queue with the head entry exposed combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module sram_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/sram_like_mem_slave.sv
// Word-organised RAM behind an SRAM-like bus: requests are queued in order
// and each completes a fixed number of cycles after reaching the queue head.
module sram_like_mem_slave
  import sram_like_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  sram_like_mem_slave_if.slave bus
);

  localparam int unsigned DEPTH = 1 << INDEX_WIDTH;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned ENT_W = 1 + 4 + INDEX_WIDTH + 32;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  logic [31:0]            ram_q [DEPTH];
  logic [3:0]             cnt_q, cnt_d;

  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [ENT_W-1:0]       push_ent, head_ent;

  logic                   head_wr;
  logic [3:0]             head_mask;
  logic [INDEX_WIDTH-1:0] head_idx;
  logic [31:0]            head_wdata;

  // The byte mask is resolved at acceptance, so size and addr[1:0] need not be queued.
  assign push_ent = {bus.data_wr,
                     byte_mask(bus.data_size, bus.data_addr[1:0]),
                     bus.data_addr[INDEX_WIDTH+1:2],
                     bus.data_wdata};

  assign head_wr    = head_ent[ENT_W-1];
  assign head_mask  = head_ent[INDEX_WIDTH+35:INDEX_WIDTH+32];
  assign head_idx   = head_ent[INDEX_WIDTH+31:32];
  assign head_wdata = head_ent[31:0];

  assign bus.data_addr_ok = bus.data_req & ~fifo_full & ~rst;
  assign bus.data_data_ok = ~rst & ~fifo_empty & (cnt_q == LAT);
  assign bus.data_rdata   = (bus.data_data_ok && !head_wr) ? ram_q[head_idx] : '0;

  assign push = bus.data_addr_ok;
  assign pop  = bus.data_data_ok;

  sram_req_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_ent),
    .head      (head_ent),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A new head restarts at 1, whether it arrives by pop-with-remainder or push-into-empty.
  always_comb begin
    cnt_d = cnt_q;
    if (pop) begin
      cnt_d = (push || (fifo_count > CNT_W'(1))) ? 4'd1 : 4'd0;
    end else if (push && fifo_empty) begin
      cnt_d = 4'd1;
    end else if (!fifo_empty && (cnt_q < LAT)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (pop && head_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (head_mask[b]) ram_q[head_idx][8*b +: 8] <= head_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Directed bench for sram_like_mem_slave with hand-computed expectations.
module tb_sram_like_mem_slave;
  import sram_like_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  sram_like_mem_slave_if bus_if ();

  sram_like_mem_slave #(
    .INDEX_WIDTH (10),
    .LATENCY     (LAT),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus_if.data_req   = 1'b0;
    bus_if.data_wr    = 1'b0;
    bus_if.data_size  = SIZE_WORD;
    bus_if.data_addr  = '0;
    bus_if.data_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus_if.data_req   = 1'b1;
    bus_if.data_wr    = wr;
    bus_if.data_size  = size;
    bus_if.data_addr  = addr;
    bus_if.data_wdata = wdata;
  endtask

  // Single transaction from an empty queue; also checks completion latency.
  task automatic xfer(input string tag, input logic wr, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
    int unsigned n;
    logic acc, done;
    drive(wr, size, addr, wdata);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = bus_if.data_addr_ok;
      next_cycle();
      n++;
    end
    idle();
    check({tag, "_accept"}, 32'(acc), 32'd1);
    done  = 1'b0;
    rdata = '0;
    n     = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      done  = bus_if.data_data_ok;
      rdata = bus_if.data_rdata;
      next_cycle();
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, n, LAT);
  endtask

  task automatic write(input string tag, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    logic [31:0] r;
    xfer(tag, 1'b1, size, addr, wdata, r);
  endtask

  task automatic read_word(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    xfer(tag, 1'b0, SIZE_WORD, addr, '0, r);
    check({tag, "_rdata"}, r, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [9:0]  acc_map, dok_map;
    logic [31:0] got [4];
    int unsigned acc_cnt, dok_cnt;
    logic        seen;

    idle();
    bus_if.data_req = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_addr_ok", 32'(bus_if.data_addr_ok), 32'd0);
    check("rst_data_ok", 32'(bus_if.data_data_ok), 32'd0);
    check("rst_rdata", bus_if.data_rdata, 32'd0);
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("idle_addr_ok", 32'(bus_if.data_addr_ok), 32'd0);
    check("idle_data_ok", 32'(bus_if.data_data_ok), 32'd0);
    next_cycle();

    // Read after reset: RAM survives reset, data_ok only in cycle 2
    write("pre5", SIZE_WORD, 32'h14, 32'hDEADBEEF);
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    drive(1'b0, SIZE_WORD, 32'h14, '0);
    @(negedge clk);
    check("r5_c0_addr_ok", 32'(bus_if.data_addr_ok), 32'd1);
    check("r5_c0_data_ok", 32'(bus_if.data_data_ok), 32'd0);
    next_cycle();
    idle();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("r5_c%0d_data_ok", c), 32'(bus_if.data_data_ok), (c == 2) ? 32'd1 : 32'd0);
      check($sformatf("r5_c%0d_rdata", c), bus_if.data_rdata, (c == 2) ? 32'hDEADBEEF : 32'd0);
      next_cycle();
    end

    // Byte writes into word 3
    write("w3", SIZE_WORD, 32'h0C, 32'h11223344);
    xfer("b0e", 1'b1, SIZE_BYTE, 32'h0E, 32'h00AB0000, r);
    check("b0e_wr_rdata", r, 32'd0);
    read_word("r3a", 32'h0C, 32'h11AB3344);
    write("b0c", SIZE_BYTE, 32'h0C, 32'h000000EE);
    read_word("r3b", 32'h0C, 32'h11AB33EE);

    // Half writes into word 8, addr[0] ignored
    write("w8", SIZE_WORD, 32'h20, 32'h00000000);
    write("h23", SIZE_HALF, 32'h23, 32'hBEEF0000);
    read_word("r8a", 32'h20, 32'hBEEF0000);
    write("h21", SIZE_HALF, 32'h21, 32'h00001234);
    read_word("r8b", 32'h20, 32'hBEEF1234);
    write("b23", SIZE_BYTE, 32'h23, 32'h77000000);
    read_word("r8c", 32'h20, 32'h77EF1234);
    write("s11", 2'b11, 32'h24, 32'hCAFEF00D);
    read_word("r9", 32'h24, 32'hCAFEF00D);

    // Back-to-back reads with a two-entry queue (no bypass when full)
    for (int i = 0; i < 4; i++) write($sformatf("pre%0d", 16 + i), SIZE_WORD, 32'h40 + 32'(4 * i), 32'hA0000000 + 32'(i));
    acc_map = '0;
    dok_map = '0;
    acc_cnt = 0;
    dok_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (acc_cnt < 4) drive(1'b0, SIZE_WORD, 32'h40 + 32'(4 * acc_cnt), '0);
      else idle();
      @(negedge clk);
      acc_map[c] = bus_if.data_addr_ok;
      dok_map[c] = bus_if.data_data_ok;
      if (bus_if.data_addr_ok) acc_cnt++;
      if (bus_if.data_data_ok) begin
        if (dok_cnt < 4) got[dok_cnt] = bus_if.data_rdata;
        dok_cnt++;
      end
      next_cycle();
    end
    idle();
    check("b2b_addr_ok_map", 32'(acc_map), 32'h02B);
    check("b2b_data_ok_map", 32'(dok_map), 32'h154);
    check("b2b_completions", dok_cnt, 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("b2b_rdata%0d", i), got[i], 32'hA0000000 + 32'(i));

    // Reset while a write is pending
    write("w12", SIZE_WORD, 32'h30, 32'h12345678);
    drive(1'b1, SIZE_WORD, 32'h30, 32'hFFFFFFFF);
    @(negedge clk);
    check("mid_accept", 32'(bus_if.data_addr_ok), 32'd1);
    next_cycle();
    rst = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check($sformatf("mid_rst%0d_addr_ok", c), 32'(bus_if.data_addr_ok), 32'd0);
      check($sformatf("mid_rst%0d_data_ok", c), 32'(bus_if.data_data_ok), 32'd0);
      next_cycle();
    end
    rst = 1'b0;
    idle();
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | bus_if.data_data_ok;
      next_cycle();
    end
    check("mid_no_data_ok", 32'(seen), 32'd0);
    read_word("r12", 32'h30, 32'h12345678);

    // Address wrap beyond INDEX_WIDTH
    write("wrap_w", SIZE_WORD, 32'h00001000, 32'h00000055);
    read_word("wrap_r", 32'h0, 32'h00000055);
    write("wrap_b", SIZE_BYTE, 32'hFFFFF001, 32'h00006600);
    read_word("wrap_r2", 32'h0, 32'h00006655);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
